// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready command queue, ALU power FSM and a single-entry
// result register in front of the accumulator ALU.
// Optional feature: define ALU_SEQ_AUTO_OFF_EN to power the ALU down after
// IDLE_CYCLES consecutive empty READY cycles.
module alu_sequencer #(
    parameter int N           = 8,
    parameter int DEPTH       = 4,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [N-1:0]           cmd_data,
    input  logic                   pwr_up,
    input  logic                   pwr_down,
    output logic                   alu_rst,
    output logic                   alu_on,
    output logic                   alu_off,
    output logic [3:0]             alu_op,
    output logic [N-1:0]           alu_in,
    input  logic [N-1:0]           alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N-1:0]           res_data,
    output logic                   err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [3:0]    OP_MAX = 4'd8;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BOOT,
        ST_READY,
        ST_DRAIN
    } state_t;

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    q_op   [DEPTH];
    logic [N-1:0]  q_data [DEPTH];

    logic accept;
    logic push;
    logic slot_free;
    logic issue;
    logic q_empty;
    logic idle_expired;
    logic off_now;

    // Handshake, issue and power-down decode from registered state
    always_comb begin
        q_empty   = (count == '0);
        cmd_ready = (count < FULL) && (state != ST_DRAIN);
        accept    = cmd_valid && cmd_ready;
        push      = accept && (cmd_op <= OP_MAX);
        slot_free = !res_valid || res_ready;
        issue     = ((state == ST_READY) || (state == ST_DRAIN)) && !q_empty && slot_free;
        // alu_off is decoded in the cycle the shutdown is decided so the ALU
        // sees it on the same edge the FSM moves to OFF.
        off_now   = ((state == ST_READY) && q_empty && (pwr_down || idle_expired)) ||
                    ((state == ST_DRAIN) && q_empty);
    end

    // ALU drive: head of queue while issuing, NOP otherwise
    always_comb begin
        alu_op  = '0;
        alu_in  = '0;
        if (issue) begin
            alu_op = q_op[rd_ptr];
            alu_in = q_data[rd_ptr];
        end
        alu_on  = 1'b0;
        alu_off = off_now;
        busy    = ((state != ST_OFF) && !q_empty) || (state == ST_DRAIN);
    end

`ifdef ALU_SEQ_AUTO_OFF_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt;
    logic          idle;

    assign idle         = (state == ST_READY) && q_empty;
    assign idle_expired = idle && (idle_cnt == IW'(IDLE_CYCLES));

    // Idle counter: consecutive empty READY cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (idle && !idle_expired) begin
            idle_cnt <= idle_cnt + IW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    logic unused_idle;
    assign unused_idle  = ^IDLE_CYCLES;
    assign idle_expired = 1'b0;
`endif

    // Power FSM with registered alu_rst (high exactly during BOOT)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_OFF;
            alu_rst <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (pwr_up && !pwr_down) begin
                        state   <= ST_BOOT;
                        alu_rst <= 1'b1;
                    end
                end
                ST_BOOT: begin
                    state   <= ST_READY;
                    alu_rst <= 1'b0;
                end
                ST_READY: begin
                    if (off_now) begin
                        state <= ST_OFF;
                    end else if (pwr_down) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (off_now) begin
                        state <= ST_OFF;
                    end
                end
                default: begin
                    state   <= ST_OFF;
                    alu_rst <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= cmd_op;
            q_data[wr_ptr] <= cmd_data;
        end
    end

    // Result register and illegal-opcode error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && (cmd_op > OP_MAX);
            if (issue) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command sequencer that sits in front of the accumulator ALU and owns all of its control inputs (`rst`, `on`, `off`, `op`, `in`). It accepts ALU commands through a valid/ready queue, manages the ALU power state, and issues at most one command per cycle. It captures each ALU result into a single-entry output register with its own valid/ready handshake.

## Interface
- `N`, 8: data width; must match the ALU `n`.
- `DEPTH`, 4: command queue depth; a power of 2, at least 2.
- `IDLE_CYCLES`, 8: empty-queue cycles before auto power-down. Used only when `ALU_SEQ_AUTO_OFF_EN` is defined.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  queue can accept a command.
- `cmd_op`  in  4  ALU opcode: NOP 0, LOAD 1, NOT 2, XOR 3, OR 4, AND 5, SUB 6, ADD 7, MULT 8.
- `cmd_data`  in  N  operand.
- `pwr_up`  in  1  power-up request.
- `pwr_down`  in  1  power-down request.
- `alu_rst`  out  1  drives ALU `rst` (active-high).
- `alu_on`  out  1  drives ALU `on`; held 0.
- `alu_off`  out  1  drives ALU `off`.
- `alu_op`  out  4  drives ALU `op`.
- `alu_in`  out  N  drives ALU `in`.
- `alu_out`  in  N  ALU combinational `out`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  N  captured result.
- `err`  out  1  one-cycle pulse when an illegal opcode is rejected.
- `busy`  out  1  high when the state is not OFF and the queue is non-empty, or when the state is DRAIN.
- `count`  out  $clog2(DEPTH)+1  queue occupancy.

## Operation
- FSM states: OFF, BOOT, READY, DRAIN.
- **OFF**
  - Drives `alu_op`=0, `alu_in`=0, `alu_rst`=0, `alu_off`=0.
  - `pwr_up` & ~`pwr_down` → BOOT.
  - `pwr_up` and `pwr_down` together → stay OFF.
- **BOOT**
  - Asserts `alu_rst`=1 for exactly one cycle, which clears the ALU accumulator and powers it on.
  - Then → READY.
- **READY: issue rule**
  - slot_free = ~`res_valid` | `res_ready`.
  - If `count`>0 and slot_free, issue the queue head:
    - drive `alu_op`/`alu_in` from the head;
    - at the edge, pop the head, load `res_data`←`alu_out` and set `res_valid`←1.
  - Otherwise drive NOP with `alu_in`=0.
  - Every legal opcode, including NOP, produces a result.
- **READY: power-down**
  - `pwr_down` with `count`=0 and nothing issued this cycle → pulse `alu_off`=1 for one cycle, then → OFF.
  - `pwr_down` with `count`>0 → DRAIN.
- **DRAIN**
  - `cmd_ready`=0.
  - Issues using the READY issue rule.
  - In the cycle after the queue becomes empty, pulses `alu_off` and → OFF.
- `pwr_up` is ignored outside OFF. `pwr_down` is ignored in BOOT and DRAIN.
- **Queue**
  - FIFO of {op, data} with wrapping pointers and an occupancy counter.
  - `cmd_ready` = (`count`<DEPTH) & state≠DRAIN. The queue accepts commands in OFF and BOOT.
  - Push and pop in the same cycle are allowed; `count` is unchanged.
- **Illegal opcodes**
  - `cmd_op`>8 with `cmd_valid` & `cmd_ready` is handshaken but not enqueued.
  - `err`=1 for the next cycle.
- `res_valid` clears at the edge with `res_ready`=1 unless a new issue reloads it in the same edge.
- `res_data` holds stable while `res_valid` & ~`res_ready`.

## Timing
- **Reset values** (`rst`=0):
  - state OFF, queue empty, `count`=0;
  - `cmd_ready`=1;
  - `alu_rst`, `alu_on`, `alu_off`=0, `alu_op`=0, `alu_in`=0;
  - `res_valid`=0, `res_data`=0, `err`=0, `busy`=0.
- Reset mid-operation discards the queue and any pending result. The ALU accumulator is cleared only by the next BOOT.
- **Latency**: command accepted at edge E into an empty queue in READY with a free slot → issued in cycle E..E+1 → `res_valid` high after edge E+1.
- Throughput is one command per cycle while `res_ready`=1.
- `alu_op`/`alu_in` are decoded from registered queue state only; there is no combinational path from `cmd_*` to `alu_*`.
- `pwr_up` in OFF → BOOT after 1 edge → READY after 2 edges.
- `alu_rst` and `alu_off` are single-cycle pulses and never both high.

## Configuration
- **`ALU_SEQ_AUTO_OFF_EN` defined**
  - An idle counter increments each READY cycle with `count`=0 and no issue, and clears otherwise.
  - When it reaches `IDLE_CYCLES`, the block pulses `alu_off` and → OFF.
- **`ALU_SEQ_AUTO_OFF_EN` undefined**
  - No idle counter; the ALU stays on until `pwr_down`.

## Test plan
- **Reset and boot**: reset, then `pwr_up` for 1 cycle → `alu_rst`=1 for exactly one cycle, READY on the next edge; all outputs 0 during reset.
- **Back-to-back issue**: LOAD 5, ADD 3, SUB 1, MULT 4 with `res_ready`=1 → `res_data` 5, 8, 7, 28 on consecutive cycles; `err`=0.
- **Back-pressure**: `res_ready`=0 after the first result, push 5 commands with DEPTH=4 →
  - `count`=4 and `cmd_ready`=0;
  - `res_data` holds 5;
  - releasing `res_ready` drains the results in order.
- **Illegal opcode**: `cmd_op`=4'hA → `err` pulses 1 cycle, `count` unchanged, no ALU issue.
- **Power-down drain**: `pwr_down` with 2 queued →
  - DRAIN with `cmd_ready`=0;
  - 2 results;
  - one-cycle `alu_off` pulse, then OFF.
- **Reset mid-DRAIN**: → `count`=0, `res_valid`=0, OFF.
- **Auto-off**: with the macro defined and `IDLE_CYCLES`=8, 8 empty READY cycles → `alu_off` pulse, then OFF. Without the macro, the block stays READY.
